// File: rtl/score_insert.sv
// Writer side of the top-N score compare handshake: owns the descending score
// buffer, requests an insert position from compare, then shift-inserts the score.
module score_insert #(
  parameter int width    = 8,
  parameter int quantity = 10,
  parameter int idx_w    = 4,
  parameter int timeout  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      score_valid,
  input  logic [width-1:0]          score_in,
  output logic                      score_ready,
  input  logic                      clear,
  output logic                      compare_data_rdy,
  output logic [width-1:0]          cmp_score,
  output logic [quantity*width-1:0] score_buffer,
  output logic [idx_w-1:0]          compare_num,
  input  logic                      compare_rdy,
  input  logic [idx_w-1:0]          insert_index,
  output logic                      done,
  output logic                      discarded,
  output logic                      timeout_err
);

  localparam int                cnt_w    = $clog2(timeout + 1);
  localparam logic [idx_w-1:0]  qty_c    = idx_w'(quantity);
  localparam logic [cnt_w-1:0]  tmo_last = cnt_w'(timeout - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, INSERT, FIN} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] buf_q [quantity];
  logic [width-1:0] buf_d [quantity];
  logic [width-1:0] cmp_score_q;
  logic [idx_w-1:0] count_q, index_q, eff_idx;
  logic [cnt_w-1:0] wait_cnt_q, wait_inc;
  logic             disc_q, tmo_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    state_d  = state_q;
    wait_inc = wait_cnt_q + cnt_w'(1);
    unique case (state_q)
      IDLE:    if (!clear && score_valid) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT: begin
        if (compare_rdy)                state_d = INSERT;
        else if (wait_inc == tmo_last)  state_d = FIN;
      end
      INSERT:  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Insert position never points past the valid entries; an index of quantity
  // or more matches no slot, leaving the buffer untouched (discard).
  always_comb begin
    eff_idx = (index_q < count_q) ? index_q : count_q;
    buf_d   = buf_q;
    if (eff_idx == '0) buf_d[0] = cmp_score_q;
    for (int p = 1; p < quantity; p++) begin
      if (idx_w'(p) == eff_idx)     buf_d[p] = cmp_score_q;
      else if (idx_w'(p) > eff_idx) buf_d[p] = buf_q[p-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is the live top-N list, so it is reset like any other state, not left as memory.
      for (int p = 0; p < quantity; p++) buf_q[p] <= '0;
      cmp_score_q <= '0;
      count_q     <= '0;
      index_q     <= '0;
      wait_cnt_q  <= '0;
      disc_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          disc_q <= 1'b0;
          tmo_q  <= 1'b0;
          if (clear) begin
            for (int p = 0; p < quantity; p++) buf_q[p] <= '0;
            count_q <= '0;
          end else if (score_valid) begin
            cmp_score_q <= score_in;
          end
        end
        REQ:  wait_cnt_q <= '0;
        WAIT: begin
          wait_cnt_q <= wait_inc;
          if (compare_rdy)               index_q <= insert_index;
          else if (wait_inc == tmo_last) tmo_q   <= 1'b1;
        end
        INSERT: begin
          for (int p = 0; p < quantity; p++) buf_q[p] <= buf_d[p];
          disc_q  <= (eff_idx >= qty_c);
          count_q <= (count_q == qty_c) ? count_q : count_q + idx_w'(1);
        end
        default: ;
      endcase
    end
  end

  assign score_ready      = (state_q == IDLE);
  assign compare_data_rdy = (state_q == REQ);
  assign done             = (state_q == FIN);
  assign discarded        = done & disc_q;
  assign timeout_err      = done & tmo_q;
  assign cmp_score        = cmp_score_q;
  assign compare_num      = count_q;

  // Slot k (1 = highest) sits at bits [k*width-1 -: width].
  for (genvar g = 0; g < quantity; g++) begin : g_pack
    assign score_buffer[g*width +: width] = buf_q[g];
  end

endmodule

// File: tb/tb_score_insert.sv
// Self-checking bench for score_insert: the bench plays the compare block and
// keeps the top-N list as a sorted queue model.
module tb_score_insert;

  localparam int W   = 8;
  localparam int Q   = 10;
  localparam int IW  = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          score_valid = 1'b0;
  logic [W-1:0]  score_in = '0;
  logic          score_ready;
  logic          clear = 1'b0;
  logic          compare_data_rdy;
  logic [W-1:0]  cmp_score;
  logic [Q*W-1:0] score_buffer;
  logic [IW-1:0] compare_num;
  logic          compare_rdy = 1'b0;
  logic [IW-1:0] insert_index = '0;
  logic          done, discarded, timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int model_q[$];

  score_insert #(.width(W), .quantity(Q), .idx_w(IW), .timeout(TMO)) dut (
    .clk(clk), .rst(rst), .score_valid(score_valid), .score_in(score_in),
    .score_ready(score_ready), .clear(clear), .compare_data_rdy(compare_data_rdy),
    .cmp_score(cmp_score), .score_buffer(score_buffer), .compare_num(compare_num),
    .compare_rdy(compare_rdy), .insert_index(insert_index), .done(done),
    .discarded(discarded), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Q*W-1:0] pack_model();
    logic [Q*W-1:0] v = '0;
    foreach (model_q[i]) v[i*W +: W] = W'(model_q[i]);
    return v;
  endfunction

  // Position after all entries >= s: a legal answer for compare.
  function automatic int sorted_pos(input int s);
    int n = 0;
    foreach (model_q[i]) if (model_q[i] >= s) n++;
    return n;
  endfunction

  task automatic txn(input int s, input int idx, input int delay);
    int  e;
    bit  exp_disc;
    check("idle_ready", score_ready, 1);
    score_valid = 1'b1;
    score_in    = W'(s);
    @(negedge clk);
    score_valid = 1'b0;
    check("req_pulse", compare_data_rdy, 1);
    check("req_score", cmp_score, s);
    check("req_num", compare_num, model_q.size());
    check("req_buf", score_buffer, pack_model());
    @(negedge clk);
    check("req_one_cycle", compare_data_rdy, 0);
    score_valid = 1'b1;
    score_in    = ~W'(s);
    repeat (delay) @(negedge clk);
    check("wait_score_stable", cmp_score, s);
    check("wait_buf_stable", score_buffer, pack_model());
    compare_rdy  = 1'b1;
    insert_index = IW'(idx);
    @(negedge clk);
    compare_rdy = 1'b0;
    score_valid = 1'b0;
    check("insert_no_done", done, 0);
    e = (idx < model_q.size()) ? idx : model_q.size();
    exp_disc = (e >= Q);
    if (!exp_disc) begin
      model_q.insert(e, s);
      if (model_q.size() > Q) void'(model_q.pop_back());
    end
    @(negedge clk);
    check("fin_done", done, 1);
    check("fin_discarded", discarded, exp_disc);
    check("fin_timeout", timeout_err, 0);
    check("fin_buf", score_buffer, pack_model());
    check("fin_num", compare_num, model_q.size());
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_q.delete();
    check("clear_num", compare_num, 0);
    check("clear_buf", score_buffer, 0);
  endtask

  initial begin
    int cycles;
    int full_vals[10] = '{14, 12, 11, 10, 8, 7, 7, 6, 5, 4};

    // Reset state
    @(negedge clk);
    check("rst_buf", score_buffer, 0);
    check("rst_num", compare_num, 0);
    check("rst_cmp", cmp_score, 0);
    check("rst_req", compare_data_rdy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", score_ready, 1);

    // Fill from empty: 15, 12, 10
    txn(15, 0, 0);
    txn(12, 1, 1);
    txn(10, 2, 0);
    check("three_buf", score_buffer, 80'h0a0c0f);
    check("three_num", compare_num, 3);
    txn(14, 1, 0);
    check("four_buf", score_buffer, 80'h0a0c0e0f);
    txn(5, 9, 2);  // clamped to position 4
    check("clamp_buf", score_buffer, 80'h050a0c0e0f);
    check("clamp_num", compare_num, 5);

    // Full buffer insert and discard
    do_clear();
    foreach (full_vals[i]) txn(full_vals[i], 15, 0);
    check("full_num", compare_num, 10);
    txn(9, 4, 0);
    check("full_ins_buf", score_buffer, 80'h05060707_08090a0b_0c0e);
    txn(3, 10, 0);
    check("disc_buf", score_buffer, 80'h05060707_08090a0b_0c0e);
    check("disc_num", compare_num, 10);

    // Timeout: compare_rdy pulsed only during REQ (must be ignored)
    score_valid = 1'b1;
    score_in    = 8'd200;
    @(negedge clk);
    score_valid  = 1'b0;
    check("tmo_req", compare_data_rdy, 1);
    compare_rdy  = 1'b1;
    insert_index = '0;
    @(negedge clk);
    compare_rdy = 1'b0;
    cycles = 1;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("tmo_latency", cycles, TMO);
    check("tmo_flag", timeout_err, 1);
    check("tmo_disc", discarded, 0);
    check("tmo_buf", score_buffer, pack_model());
    check("tmo_num", compare_num, model_q.size());
    @(negedge clk);
    check("tmo_ready", score_ready, 1);

    // Randomized transactions against the queue model
    do_clear();
    for (int n = 0; n < 40; n++) begin
      int s, idx;
      s = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) idx = sorted_pos(s);
      else                           idx = $urandom_range(0, 15);
      txn(s, idx, $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) do_clear();
    end

    // Reset during WAIT
    score_valid = 1'b1;
    score_in    = 8'd77;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    model_q.delete();
    check("midrst_buf", score_buffer, 0);
    check("midrst_num", compare_num, 0);
    check("midrst_cmp", cmp_score, 0);
    check("midrst_ready", score_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done_after", done, 0);

    // clear beats score_valid in IDLE
    txn(42, 0, 0);
    clear       = 1'b1;
    score_valid = 1'b1;
    score_in    = 8'd99;
    @(negedge clk);
    clear       = 1'b0;
    score_valid = 1'b0;
    model_q.delete();
    check("clrv_no_req", compare_data_rdy, 0);
    check("clrv_ready", score_ready, 1);
    check("clrv_num", compare_num, 0);
    check("clrv_buf", score_buffer, 0);
    txn(50, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/score_insert.md
Name: score_insert

Overview:
- Writer/initiator side of the top-N score compare handshake; owns the descending-sorted score buffer.
- Accepts new scores upstream, presents score + buffer + valid-entry count to the `compare` block, waits for its insert position, then shift-inserts the score.
- Sits between the score generator and `compare`; its buffer is the system's live top-N list.

Parameters:
- width, 8, bits per score
- quantity, 10, buffer depth (N)
- idx_w, 4, width of index/count fields; must satisfy 2^idx_w > quantity
- timeout, 64, max cycles to wait for compare_rdy before abort

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- score_valid  in  1  upstream offers score_in
- score_in  in  width  new score
- score_ready  out  1  high when block accepts a score (IDLE only)
- clear  in  1  empty the buffer (honoured in IDLE only)
- compare_data_rdy  out  1  one-cycle request pulse to compare
- cmp_score  out  width  score under comparison, held stable REQ..WAIT
- score_buffer  out  quantity*width  slot k (1=highest) at bits [k*width-1 -: width]
- compare_num  out  idx_w  number of valid entries (0..quantity)
- compare_rdy  in  1  compare result valid (sampled in WAIT)
- insert_index  in  idx_w  0-based insert position from compare
- done  out  1  one-cycle pulse when a transaction ends
- discarded  out  1  valid with done: score not placed in the top N
- timeout_err  out  1  valid with done: compare never answered

Behaviour:
- Reset (async): state IDLE; score_buffer all zero; compare_num 0; cmp_score 0; compare_data_rdy, done, discarded, timeout_err 0. score_ready 1 after reset release.
- FSM states: IDLE, REQ, WAIT, INSERT, FIN.
- IDLE: score_ready=1. If clear=1, zero the buffer and set compare_num=0; clear wins over score_valid in the same cycle. Otherwise, on score_valid=1, latch score_in into cmp_score and go to REQ.
- REQ: compare_data_rdy=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - compare_rdy=1: latch insert_index, go to INSERT.
  - Counter reaches timeout-1 with no compare_rdy: go to FIN with timeout_err=1 and the buffer unchanged.
  - A compare_rdy arriving in any state other than WAIT is ignored.
- INSERT (single cycle):
  - Effective index e = min(insert_index, compare_num).
  - If e >= quantity: buffer unchanged, discarded=1.
  - Else: slots at 0-based positions p > e take old position p-1; position e takes cmp_score; positions < e are unchanged. The old last entry drops when full.
  - compare_num increments, saturating at quantity.
  - Go to FIN.
- FIN: done=1 for one cycle; discarded/timeout_err valid this cycle only. Return to IDLE.
- Latency: score accepted at edge T; compare_data_rdy high in cycle T+1. Buffer updates at the edge ending INSERT; done high the following cycle. Minimum accept-to-done is 4 cycles with a 1-cycle compare response.
- score_buffer, compare_num and cmp_score are stable from REQ through the end of WAIT.
- score_in/score_valid outside IDLE are ignored; there is no queuing, and the upstream holds score_valid until score_ready.
- Ties: the position chosen by compare is trusted; no reordering here.
- Reset mid-transaction: immediate return to reset values. Any partially completed request is lost, and no done is issued.

Test Plan:
- Full buffer 14,12,11,10,8,7,7,6,5,4 (count 10), score 9, compare answers insert_index=4 -> buffer 14,12,11,10,9,8,7,7,6,5; compare_num 10; done=1, discarded=0.
- After reset, insert 15 then 12 then 10 with indices 0,1,2 -> buffer 15,12,10,0,...; compare_num 3. compare_data_rdy must be a 1-cycle pulse each time, with compare_num showing 0, 1, 2 during the respective requests.
- Full buffer, score 3, insert_index=10 -> buffer unchanged, compare_num 10, done with discarded=1.
- Count 3 (15,12,10), score 14, insert_index=1 -> 15,14,12,10; count 4. Then index 9 with count 4 -> clamped to 4, score placed at position 4.
- compare_rdy held low -> done with timeout_err=1 exactly timeout cycles after REQ; buffer unchanged; score_ready returns 1.
- rst asserted during WAIT -> outputs reset asynchronously, no done. clear+score_valid together in IDLE -> buffer emptied, score not accepted.
